// File: rtl/vga_mix_pkg.sv
// rtl/vga_mix_pkg.sv - shared types and helpers for the VGA layer mixer
// Purpose: mode encodings, default colour width, rgb width and channel pack/unpack helpers.
// Ports: none (package).
package vga_mix_pkg;

  typedef enum logic [1:0] {
    MODE_PLAY  = 2'd0,
    MODE_FLASH = 2'd1,
    MODE_OVER  = 2'd2
  } mode_e;

  localparam int DEF_COLOR_W = 4;

  // Channel indices into a packed {r,g,b} word.
  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  function automatic int rgb_width(input int color_w);
    return 3 * color_w;
  endfunction

  // Bit offset of a channel inside a packed {r,g,b} word (red in the MSBs).
  function automatic int chan_off(input int ch, input int color_w);
    return (2 - ch) * color_w;
  endfunction

endpackage

// File: rtl/vga_layer_mixer_if.sv
// rtl/vga_layer_mixer_if.sv - pixel/timing bundle between layer generators, mixer and VGA pins
// Purpose: groups per-layer pixels, raw timing and composited output of the mixer.
// Ports (signals): layer_rgb, layer_en, text_en, hsync_in, vsync_in, de_in (to mixer);
//                  vga_red, vga_green, vga_blue, hsync_out, vsync_out, de_out (from mixer).
// Modports: master = pixel source / sink side, slave = mixer side.
interface vga_layer_mixer_if #(
  parameter int NUM_LAYERS = 3,
  parameter int COLOR_W    = 4
);
  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0]           layer_en;
  logic                            text_en;
  logic                            hsync_in;
  logic                            vsync_in;
  logic                            de_in;
  logic [COLOR_W-1:0]              vga_red;
  logic [COLOR_W-1:0]              vga_green;
  logic [COLOR_W-1:0]              vga_blue;
  logic                            hsync_out;
  logic                            vsync_out;
  logic                            de_out;

  modport master (
    output layer_rgb, layer_en, text_en, hsync_in, vsync_in, de_in,
    input  vga_red, vga_green, vga_blue, hsync_out, vsync_out, de_out
  );

  modport slave (
    input  layer_rgb, layer_en, text_en, hsync_in, vsync_in, de_in,
    output vga_red, vga_green, vga_blue, hsync_out, vsync_out, de_out
  );
endinterface

// File: rtl/vga_frame_tick.sv
// rtl/vga_frame_tick.sv - vsync rising-edge detector producing a one-cycle frame tick
// Purpose: tick is high for one cycle, one cycle after vsync is first sampled high.
// Ports: clk, rst (sync active-high), vsync (in), tick (out).
module vga_frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic tick
);

  logic vsync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      tick    <= 1'b0;
    end else begin
      vsync_q <= vsync;
      tick    <= vsync & ~vsync_q;
    end
  end

endmodule

// File: rtl/vga_layer_mixer.sv
// rtl/vga_layer_mixer.sv - two-stage priority compositor with game-over flash/text sequence
// Purpose: stage 1 picks the highest-index opaque layer (or BG_COLOR); stage 2 applies the
//          display mode and blanking; sync/DE are delayed to match (latency 2).
// Ports: clk, rst (sync active-high), the_end, restart, mode[1:0], pix (vga_layer_mixer_if.slave),
//        blend_en only when MIXER_BLEND_EN is defined.
// Config: MIXER_BLEND_EN - averages the top opaque layer with the one beneath (or BG).
module vga_layer_mixer
  import vga_mix_pkg::*;
#(
  parameter int                   NUM_LAYERS   = 3,
  parameter int                   COLOR_W      = DEF_COLOR_W,
  parameter int                   FLASH_FRAMES = 60,
  parameter int                   BLINK_FRAMES = 8,
  parameter logic [3*COLOR_W-1:0] BG_COLOR     = '0,
  parameter logic [3*COLOR_W-1:0] TEXT_COLOR   = 12'h0F0
) (
  input  logic               clk,
  input  logic               rst,
`ifdef MIXER_BLEND_EN
  input  logic               blend_en,
`endif
  input  logic               the_end,
  input  logic               restart,
  output logic [1:0]         mode,
  vga_layer_mixer_if.slave   pix
);

  localparam int RGB_W = rgb_width(COLOR_W);
  localparam int FC_W  = $clog2(FLASH_FRAMES + 1);
  localparam int BC_W  = $clog2(BLINK_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_FRAMES - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

  logic frame_tick;

  vga_frame_tick u_frame_tick (
    .clk   (clk),
    .rst   (rst),
    .vsync (pix.vsync_in),
    .tick  (frame_tick)
  );

  // Stage 1: priority select. Later (higher) indices overwrite earlier ones.
  logic [RGB_W-1:0] top_rgb;
  logic [RGB_W-1:0] mix_rgb;
`ifdef MIXER_BLEND_EN
  logic [RGB_W-1:0] under_rgb;
  logic             any_en;
  logic [COLOR_W:0] ch_sum;
`endif

  always_comb begin
    top_rgb = BG_COLOR;
`ifdef MIXER_BLEND_EN
    under_rgb = BG_COLOR;
    any_en    = 1'b0;
`endif
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (pix.layer_en[i]) begin
`ifdef MIXER_BLEND_EN
        under_rgb = top_rgb;
        any_en    = 1'b1;
`endif
        top_rgb = pix.layer_rgb[i*RGB_W +: RGB_W];
      end
    end
  end

`ifdef MIXER_BLEND_EN
  // Sum at COLOR_W+1 bits so the carry survives the halving.
  always_comb begin
    mix_rgb = top_rgb;
    ch_sum  = '0;
    if (blend_en && any_en) begin
      for (int c = 0; c < 3; c++) begin
        ch_sum = {1'b0, top_rgb[chan_off(c, COLOR_W) +: COLOR_W]}
               + {1'b0, under_rgb[chan_off(c, COLOR_W) +: COLOR_W]};
        mix_rgb[chan_off(c, COLOR_W) +: COLOR_W] = ch_sum[COLOR_W:1];
      end
    end
  end
`else
  assign mix_rgb = top_rgb;
`endif

  logic [RGB_W-1:0] s1_rgb;
  logic             s1_text, s1_hs, s1_vs, s1_de;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rgb  <= '0;
      s1_text <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_de   <= 1'b0;
    end else begin
      s1_rgb  <= mix_rgb;
      s1_text <= pix.text_en;
      s1_hs   <= pix.hsync_in;
      s1_vs   <= pix.vsync_in;
      s1_de   <= pix.de_in;
    end
  end

  // Game-state FSM: requests latch as pending flags, transitions only on frame ticks.
  mode_e            state_q, state_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [BC_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic             phase_on_q, phase_on_d;
  logic             end_pend_q, end_pend_d;
  logic             rst_pend_q, rst_pend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MODE_PLAY;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b0;
      end_pend_q  <= 1'b0;
      rst_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_on_q  <= phase_on_d;
      end_pend_q  <= end_pend_d;
      rst_pend_q  <= rst_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_on_d  = phase_on_q;
    end_pend_d  = end_pend_q;
    rst_pend_d  = rst_pend_q;
    case (state_q)
      MODE_PLAY: begin
        if (frame_tick && end_pend_q) begin
          state_d     = MODE_FLASH;
          frame_cnt_d = '0;
          blink_cnt_d = '0;
          phase_on_d  = 1'b1;
          end_pend_d  = 1'b0;
        end else if (the_end) begin
          end_pend_d = 1'b1;
        end
      end
      MODE_FLASH, MODE_OVER: begin
        if (restart) rst_pend_d = 1'b1;
        if (frame_tick) begin
          if (rst_pend_q) begin
            state_d     = MODE_PLAY;
            rst_pend_d  = 1'b0;
            end_pend_d  = 1'b0;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            phase_on_d  = 1'b0;
          end else if (state_q == MODE_FLASH) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (frame_cnt_q == FC_LAST) state_d = MODE_OVER;
            if (blink_cnt_q == BC_LAST) begin
              blink_cnt_d = '0;
              phase_on_d  = ~phase_on_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = MODE_PLAY;
    endcase
  end

  assign mode = state_q;

  // Stage 2: mode apply; blanking wins over everything.
  logic [RGB_W-1:0] shown_rgb;
  logic [RGB_W-1:0] s2_rgb;
  logic             s2_hs, s2_vs, s2_de;

  always_comb begin
    shown_rgb = '0;
    if (s1_de) begin
      case (state_q)
        MODE_PLAY:  shown_rgb = s1_rgb;
        MODE_FLASH: if (phase_on_q) shown_rgb = s1_rgb;
        MODE_OVER:  if (s1_text) shown_rgb = TEXT_COLOR;
        default:    shown_rgb = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_rgb <= '0;
      s2_hs  <= 1'b0;
      s2_vs  <= 1'b0;
      s2_de  <= 1'b0;
    end else begin
      s2_rgb <= shown_rgb;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      s2_de  <= s1_de;
    end
  end

  assign pix.vga_red   = s2_rgb[chan_off(CH_R, COLOR_W) +: COLOR_W];
  assign pix.vga_green = s2_rgb[chan_off(CH_G, COLOR_W) +: COLOR_W];
  assign pix.vga_blue  = s2_rgb[chan_off(CH_B, COLOR_W) +: COLOR_W];
  assign pix.hsync_out = s2_hs;
  assign pix.vsync_out = s2_vs;
  assign pix.de_out    = s2_de;

endmodule
